des_round_engine: RTL

//  Parametrised DES 16-round Feistel core with valid/ready handshakes and an encrypt/decrypt select.

---
 rtl/des_round_engine.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/des_round_engine.sv
// DES 16-round Feistel core. It takes a post-IP block, runs ROUNDS_PER_CYCLE
// unrolled rounds per clock and returns the pre-IP^-1 block {R16,L16}.
// The block is accepted and returned through valid/ready handshakes.

// Expansion E of the right half, followed by the round-key XOR.
module exp_per (
  input  logic [31:0] r,
  input  logic [47:0] k,
  output logic [47:0] x
);
  logic [47:0] e;

  // Each 6-bit group j takes DES bits 4j..4j+5 (1-based, wrapping 0->32, 33->1)
  always_comb begin
    e = '0;
    for (int unsigned j = 0; j < 8; j++) begin
      for (int unsigned m = 0; m < 6; m++) begin
        e[47 - (6*j + m)] = r[31 - ((4*j + m + 31) % 32)];
      end
    end
  end

  assign x = e ^ k;
endmodule

// S-box substitution (48 -> 32) followed by the P permutation.
module box (
  input  logic [47:0] x,
  output logic [31:0] f
);
  // Each S-box row holds 16 entries, column 0 in the top nibble; rows 0..3 are concatenated
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  localparam int unsigned P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  logic [31:0] s_out;
  logic [5:0]  six;
  logic [5:0]  idx;

  // Row is the outer bit pair {b1,b6} and column is the inner four bits b2..b5
  always_comb begin
    s_out = '0;
    six   = '0;
    idx   = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      six = x[47 - 6*b -: 6];
      idx = {six[5], six[0], six[4:1]};
      s_out[31 - 4*b -: 4] = SBOX[b][255 - 4*idx -: 4];
    end
  end

  // P permutation: output bit i (1-based) takes S-box output bit P_TAB[i]
  always_comb begin
    f = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      f[31 - i] = s_out[32 - P_TAB[i]];
    end
  end
endmodule

module des_round_engine #(
  parameter int unsigned ROUNDS_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         decrypt,
  input  logic [63:0]  data_in,
  input  logic [767:0] round_keys,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  data_out,
  output logic         busy
);
  localparam int unsigned ITERS = 16 / ROUNDS_PER_CYCLE;
  localparam int unsigned IW    = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [IW-1:0] ITER_LAST = IW'(ITERS - 1);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
        ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rpc
    $error("des_round_engine: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         state;
  logic [IW-1:0]  iter;
  logic [31:0]    l_reg;
  logic [31:0]    r_reg;
  logic [767:0]   key_reg;
  logic           dec_reg;

  logic [47:0]    key_arr [16];
  logic [31:0]    l_ch [ROUNDS_PER_CYCLE + 1];
  logic [31:0]    r_ch [ROUNDS_PER_CYCLE + 1];

  // K1 sits in the top 48 bits of the key bus, K16 in the bottom 48
  for (genvar j = 0; j < 16; j++) begin : g_key
    assign key_arr[j] = key_reg[767 - 48*j -: 48];
  end

  assign l_ch[0] = l_reg;
  assign r_ch[0] = r_reg;

  // Combinational chain of ROUNDS_PER_CYCLE Feistel rounds from the registered halves
  for (genvar k = 0; k < ROUNDS_PER_CYCLE; k++) begin : g_round
    logic [3:0]  rnd_idx;
    logic [3:0]  key_idx;
    logic [47:0] x48;
    logic [31:0] f32;

    assign rnd_idx = 4'(32'(iter) * ROUNDS_PER_CYCLE + k);
    assign key_idx = dec_reg ? (4'd15 - rnd_idx) : rnd_idx;

    exp_per u_exp_per (
      .r (r_ch[k]),
      .k (key_arr[key_idx]),
      .x (x48)
    );

    box u_box (
      .x (x48),
      .f (f32)
    );

    assign l_ch[k + 1] = r_ch[k];
    assign r_ch[k + 1] = l_ch[k] ^ f32;
  end

  // In DONE a new block can be taken on the same edge the finished one leaves
  assign in_ready = (state == S_IDLE) || ((state == S_DONE) && out_ready);

  // Control FSM with the datapath registers and registered outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= S_IDLE;
      iter      <= '0;
      l_reg     <= '0;
      r_reg     <= '0;
      key_reg   <= '0;
      dec_reg   <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
      busy      <= 1'b0;
    end else if (clear) begin
      state     <= S_IDLE;
      iter      <= '0;
      l_reg     <= '0;
      r_reg     <= '0;
      dec_reg   <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            l_reg   <= data_in[63:32];
            r_reg   <= data_in[31:0];
            key_reg <= round_keys;
            dec_reg <= decrypt;
            iter    <= '0;
            busy    <= 1'b1;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          l_reg <= l_ch[ROUNDS_PER_CYCLE];
          r_reg <= r_ch[ROUNDS_PER_CYCLE];
          if (iter == ITER_LAST) begin
            iter      <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            data_out  <= {r_ch[ROUNDS_PER_CYCLE], l_ch[ROUNDS_PER_CYCLE]};
            state     <= S_DONE;
          end else begin
            iter <= iter + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            if (in_valid) begin
              l_reg   <= data_in[63:32];
              r_reg   <= data_in[31:0];
              key_reg <= round_keys;
              dec_reg <= decrypt;
              iter    <= '0;
              busy    <= 1'b1;
              state   <= S_RUN;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule
